// File: rtl/exc_sequencer.sv
// Exception/ERET control-flow sequencer and owner of EPC, Status.EXL, Cause and BadVAddr.
// Optional macro EXC_SEQ_DELAY_SLOT_EN enables branch-delay-slot handling (BD and EPC-4).
module exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'hbfc0_0380
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_eret,
  input  logic [4:0]  req_exccode,
  input  logic [31:0] req_pc,
  input  logic [31:0] req_badvaddr,
  input  logic        req_delayed,
  input  logic [5:0]  int_i,
  input  logic [5:0]  int_mask_i,
  input  logic        int_ie_i,
  output logic        int_pending_o,
  output logic        flush_o,
  input  logic        flush_ack,
  output logic        redir_valid,
  input  logic        redir_ready,
  output logic [31:0] redir_pc,
  output logic [31:0] epc_o,
  output logic [31:0] badvaddr_o,
  output logic        status_exl_o,
  output logic [4:0]  cause_exccode_o,
  output logic        cause_bd_o,
  output logic [5:0]  cause_ip_o,
  output logic        fatal_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        accept;

  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic        exl;
  logic [4:0]  exccode;
  logic        bd;
  logic [31:0] target;
  logic        fatal;
  logic [5:0]  int_meta;
  logic [5:0]  cause_ip;

  logic [31:0] epc_new;
  logic        bd_new;
  logic        fatal_set;

  function automatic logic addr_exc(input logic [4:0] code);
    return (code == 5'd4) || (code == 5'd5);
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next  = state;
    req_ready   = 1'b0;
    flush_o     = 1'b0;
    redir_valid = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        flush_o = 1'b1;
        if (flush_ack) state_next = REDIRECT;
      end
      REDIRECT: begin
        redir_valid = 1'b1;
        if (redir_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Without delay-slot support a delayed request is still processed, but flagged.
  always_comb begin
    epc_new   = req_pc;
    bd_new    = 1'b0;
    fatal_set = 1'b0;
`ifdef EXC_SEQ_DELAY_SLOT_EN
    if (req_delayed) begin
      epc_new = req_pc - 32'd4;
      bd_new  = 1'b1;
    end
`else
    fatal_set = req_delayed;
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      epc      <= '0;
      badvaddr <= '0;
      exl      <= 1'b0;
      exccode  <= '0;
      bd       <= 1'b0;
      target   <= '0;
      fatal    <= 1'b0;
    end else if (accept) begin
      if (fatal_set) fatal <= 1'b1;
      if (req_eret) begin
        target <= epc;
        exl    <= 1'b0;
      end else begin
        // A nested exception keeps the original return context.
        if (!exl) begin
          epc <= epc_new;
          bd  <= bd_new;
          exl <= 1'b1;
        end
        exccode <= req_exccode;
        if (addr_exc(req_exccode)) badvaddr <= req_badvaddr;
        target <= EXC_VECTOR;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      int_meta <= '0;
      cause_ip <= '0;
    end else begin
      int_meta <= int_i;
      cause_ip <= int_meta;
    end
  end

  assign int_pending_o   = (|(cause_ip & int_mask_i)) & int_ie_i & ~exl;
  assign redir_pc        = target;
  assign epc_o           = epc;
  assign badvaddr_o      = badvaddr;
  assign status_exl_o    = exl;
  assign cause_exccode_o = exccode;
  assign cause_bd_o      = bd;
  assign cause_ip_o      = cause_ip;
  assign fatal_o         = fatal;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: exception, ERET, nesting, delay slot, interrupts, slow handshakes, reset.
module tb_exc_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic        req_eret;
  logic [4:0]  req_exccode;
  logic [31:0] req_pc;
  logic [31:0] req_badvaddr;
  logic        req_delayed;
  logic [5:0]  int_i;
  logic [5:0]  int_mask_i;
  logic        int_ie_i;
  logic        int_pending_o;
  logic        flush_o;
  logic        flush_ack;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;
  logic [31:0] epc_o;
  logic [31:0] badvaddr_o;
  logic        status_exl_o;
  logic [4:0]  cause_exccode_o;
  logic        cause_bd_o;
  logic [5:0]  cause_ip_o;
  logic        fatal_o;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] VEC = 32'hbfc0_0380;

  exc_sequencer dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_eret(req_eret),
    .req_exccode(req_exccode), .req_pc(req_pc), .req_badvaddr(req_badvaddr),
    .req_delayed(req_delayed),
    .int_i(int_i), .int_mask_i(int_mask_i), .int_ie_i(int_ie_i),
    .int_pending_o(int_pending_o),
    .flush_o(flush_o), .flush_ack(flush_ack),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .epc_o(epc_o), .badvaddr_o(badvaddr_o), .status_exl_o(status_exl_o),
    .cause_exccode_o(cause_exccode_o), .cause_bd_o(cause_bd_o),
    .cause_ip_o(cause_ip_o), .fatal_o(fatal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns in the first FLUSH cycle.
  task automatic do_req(input logic eret, input logic [4:0] code, input logic [31:0] pc,
                        input logic [31:0] bva, input logic dly);
    req_eret     = eret;
    req_exccode  = code;
    req_pc       = pc;
    req_badvaddr = bva;
    req_delayed  = dly;
    req_valid    = 1'b1;
    step();
    req_valid    = 1'b0;
    req_delayed  = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_eret = 1'b0; req_exccode = '0;
    req_pc = '0; req_badvaddr = '0; req_delayed = 1'b0;
    int_i = '0; int_mask_i = '0; int_ie_i = 1'b0;
    flush_ack = 1'b1; redir_ready = 1'b1;
    step(); step();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_flush", {31'd0, flush_o}, 32'd0);
    chk("rst_redir", {31'd0, redir_valid}, 32'd0);
    chk("rst_epc", epc_o, 32'd0);
    chk("rst_exl", {31'd0, status_exl_o}, 32'd0);
    chk("rst_fatal", {31'd0, fatal_o}, 32'd0);
    resetn = 1'b1;
    step();

    // Address error exception, handshakes tied high.
    do_req(1'b0, 5'd4, 32'h8000_0010, 32'h1234_5677, 1'b0);
    chk("e1_flush", {31'd0, flush_o}, 32'd1);
    chk("e1_ready_busy", {31'd0, req_ready}, 32'd0);
    chk("e1_epc", epc_o, 32'h8000_0010);
    chk("e1_bva", badvaddr_o, 32'h1234_5677);
    chk("e1_exl", {31'd0, status_exl_o}, 32'd1);
    chk("e1_code", {27'd0, cause_exccode_o}, 32'd4);
    step();
    chk("e1_redir_v", {31'd0, redir_valid}, 32'd1);
    chk("e1_redir_pc", redir_pc, VEC);
    step();
    chk("e1_ready_back", {31'd0, req_ready}, 32'd1);
    chk("e1_redir_off", {31'd0, redir_valid}, 32'd0);

    // ERET back to EPC.
    do_req(1'b1, 5'd0, 32'h0, 32'h0, 1'b0);
    chk("r1_exl", {31'd0, status_exl_o}, 32'd0);
    chk("r1_code", {27'd0, cause_exccode_o}, 32'd4);
    chk("r1_epc", epc_o, 32'h8000_0010);
    step();
    chk("r1_redir_pc", redir_pc, 32'h8000_0010);
    step();
    chk("r1_ready", {31'd0, req_ready}, 32'd1);

    // Syscall-like exception: BadVAddr must not change for code 8.
    do_req(1'b0, 5'd8, 32'h8000_0050, 32'hdead_beef, 1'b0);
    chk("e2_epc", epc_o, 32'h8000_0050);
    chk("e2_bva_keep", badvaddr_o, 32'h1234_5677);
    step(); step();
    // Nested exception while EXL=1.
    do_req(1'b0, 5'd10, 32'h8000_0100, 32'h0, 1'b0);
    chk("n_epc_keep", epc_o, 32'h8000_0050);
    chk("n_code", {27'd0, cause_exccode_o}, 32'd10);
    chk("n_exl", {31'd0, status_exl_o}, 32'd1);
    step();
    chk("n_redir_pc", redir_pc, VEC);
    step();
    do_req(1'b1, 5'd0, 32'h0, 32'h0, 1'b0);
    step();
    chk("r2_redir_pc", redir_pc, 32'h8000_0050);
    step();

    // Delayed exception.
    do_req(1'b0, 5'd5, 32'h8000_0024, 32'h0000_0abc, 1'b1);
`ifdef EXC_SEQ_DELAY_SLOT_EN
    chk("d_epc", epc_o, 32'h8000_0020);
    chk("d_bd", {31'd0, cause_bd_o}, 32'd1);
    chk("d_fatal", {31'd0, fatal_o}, 32'd0);
`else
    chk("d_epc", epc_o, 32'h8000_0024);
    chk("d_bd", {31'd0, cause_bd_o}, 32'd0);
    chk("d_fatal", {31'd0, fatal_o}, 32'd1);
`endif
    chk("d_bva", badvaddr_o, 32'h0000_0abc);
    step(); step();
    do_req(1'b1, 5'd0, 32'h0, 32'h0, 1'b0);
    step(); step();
`ifndef EXC_SEQ_DELAY_SLOT_EN
    chk("d_fatal_sticky", {31'd0, fatal_o}, 32'd1);
`endif

    // Interrupt synchronizer and pending logic (EXL=0 here).
    int_i = 6'b000100; int_mask_i = 6'b000100; int_ie_i = 1'b1;
    step();
    chk("i_ip_1", {26'd0, cause_ip_o}, 32'd0);
    chk("i_pend_1", {31'd0, int_pending_o}, 32'd0);
    step();
    chk("i_ip_2", {26'd0, cause_ip_o}, 32'b000100);
    chk("i_pend_2", {31'd0, int_pending_o}, 32'd1);
    int_ie_i = 1'b0;
    #1;
    chk("i_pend_ie0", {31'd0, int_pending_o}, 32'd0);
    int_ie_i = 1'b1; int_mask_i = 6'b000010;
    #1;
    chk("i_pend_mask", {31'd0, int_pending_o}, 32'd0);
    int_i = '0; int_mask_i = '0; int_ie_i = 1'b0;
    step();

    // Slow handshakes: flush_ack after 5 cycles, redir_ready held low.
    flush_ack = 1'b0; redir_ready = 1'b0;
    do_req(1'b0, 5'd12, 32'h8000_0200, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("s_flush_%0d", i), {31'd0, flush_o}, 32'd1);
      if (i == 1) redir_ready = 1'b1;
      if (i == 2) redir_ready = 1'b0;
      if (i == 3) begin
        req_exccode = 5'd7; req_eret = 1'b0; req_valid = 1'b1;
      end
      if (i == 4) begin
        chk("s_busy_ready", {31'd0, req_ready}, 32'd0);
        chk("s_busy_code", {27'd0, cause_exccode_o}, 32'd12);
        req_valid = 1'b0;
      end
      step();
    end
    chk("s_flush_5", {31'd0, flush_o}, 32'd1);
    flush_ack = 1'b1;
    step();
    flush_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s_rv_%0d", i), {31'd0, redir_valid}, 32'd1);
      chk($sformatf("s_rpc_%0d", i), redir_pc, VEC);
      if (i == 0) flush_ack = 1'b1;
      if (i == 1) flush_ack = 1'b0;
      if (i < 3) step();
    end
    chk("s_epc", epc_o, 32'h8000_0200);

    // Asynchronous reset mid-REDIRECT.
    resetn = 1'b0;
    #1;
    chk("x_redir_v", {31'd0, redir_valid}, 32'd0);
    chk("x_ready", {31'd0, req_ready}, 32'd1);
    chk("x_epc", epc_o, 32'd0);
    chk("x_bva", badvaddr_o, 32'd0);
    chk("x_exl", {31'd0, status_exl_o}, 32'd0);
    chk("x_code", {27'd0, cause_exccode_o}, 32'd0);
    chk("x_bd", {31'd0, cause_bd_o}, 32'd0);
    chk("x_ip", {26'd0, cause_ip_o}, 32'd0);
    chk("x_fatal", {31'd0, fatal_o}, 32'd0);
    chk("x_rpc", redir_pc, 32'd0);
    step();
    resetn = 1'b1;
    step();
    chk("x_idle", {31'd0, req_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
